// File: rtl/wb_trace_monitor.sv
// Run-window controller and writeback trace FIFO for the multi-cycle core.
// Optional feature macro: TRACE_CYCLE_STAMP_EN (adds per-entry cycle stamp and rd_cycle output).
module wb_trace_monitor #(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int DEPTH       = 8,
    parameter int CYCLE_LIMIT = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       run_en,
    input  logic                       wb_en,
    input  logic [REG_AW-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [REG_AW-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       overflow,
    output logic [15:0]                cycle_cnt,
    output logic [15:0]                retire_cnt,
    output logic                       done,
`ifdef TRACE_CYCLE_STAMP_EN
    output logic [15:0]                rd_cycle,
`endif
    output logic [1:0]                 dbg_state
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t              r_state;
    logic                r_run_en;
    logic                r_done;
    logic [15:0]         r_cycle_cnt;
    logic [15:0]         r_retire_cnt;
    logic                r_overflow;
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic [REG_AW-1:0]   r_mem_addr [DEPTH];
    logic [DATA_W-1:0]   r_mem_data [DEPTH];
`ifdef TRACE_CYCLE_STAMP_EN
    logic [15:0]         r_mem_cyc  [DEPTH];
`endif

    logic w_empty, w_full, w_pop, w_cap, w_push, w_drop, w_clear, w_last;

    // Handshake: a pop happens on an edge where rd_en=1 and rd_valid=1; rd_addr/rd_data
    // present the head entry beforehand (show-ahead), so no read latency is involved.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = rd_en && !w_empty;
    assign w_cap   = (r_state == S_RUN) && wb_en;
    assign w_push  = w_cap && (!w_full || w_pop);
    assign w_drop  = w_cap && w_full && !w_pop;
    assign w_clear = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last  = (r_cycle_cnt == 16'(CYCLE_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_run_en <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_state  <= S_RUN;
                    r_run_en <= 1'b1;
                end
                S_RUN: if (w_last) begin
                    r_state  <= S_DRAIN;
                    r_run_en <= 1'b0;
                end
                // Registered count: a pop that empties the FIFO is seen as empty one edge later.
                S_DRAIN: if (w_empty) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_DONE: if (start) begin
                    r_state  <= S_RUN;
                    r_run_en <= 1'b1;
                    r_done   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
            r_overflow   <= 1'b0;
        end else if (w_clear) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (r_state == S_RUN && r_cycle_cnt != 16'hFFFF)
                r_cycle_cnt <= r_cycle_cnt + 16'd1;
            if (w_cap && r_retire_cnt != 16'hFFFF)
                r_retire_cnt <= r_retire_cnt + 16'd1;
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end

    // Storage needs no reset: every read path is gated by the occupancy count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_addr[r_wr_ptr] <= wb_addr;
            r_mem_data[r_wr_ptr] <= wb_data;
`ifdef TRACE_CYCLE_STAMP_EN
            r_mem_cyc[r_wr_ptr]  <= r_cycle_cnt;
`endif
        end
    end

    assign run_en     = r_run_en;
    assign done       = r_done;
    assign rd_valid   = !w_empty;
    assign rd_addr    = w_empty ? '0 : r_mem_addr[r_rd_ptr];
    assign rd_data    = w_empty ? '0 : r_mem_data[r_rd_ptr];
`ifdef TRACE_CYCLE_STAMP_EN
    assign rd_cycle   = w_empty ? '0 : r_mem_cyc[r_rd_ptr];
`endif
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign cycle_cnt  = r_cycle_cnt;
    assign retire_cnt = r_retire_cnt;
    assign dbg_state  = r_state;
endmodule

// File: tb/tb_wb_trace_monitor.sv
// Directed bench for wb_trace_monitor: table of run-window patterns plus hand sequences.
module tb_wb_trace_monitor;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int DEPTH  = 8;
    localparam int LIMIT  = 12;
    localparam int EW     = REG_AW + DATA_W + 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              run_en;
    logic              wb_en = 1'b0;
    logic [REG_AW-1:0] wb_addr = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              rd_en = 1'b0;
    logic              rd_valid;
    logic [REG_AW-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [3:0]        fifo_count;
    logic              overflow;
    logic [15:0]       cycle_cnt;
    logic [15:0]       retire_cnt;
    logic              done;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [15:0]       rd_cycle;
`endif
    logic [1:0]        dbg_state;

    wb_trace_monitor #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .CYCLE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .run_en(run_en),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .rd_en(rd_en),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
        .fifo_count(fifo_count), .overflow(overflow), .cycle_cnt(cycle_cnt),
        .retire_cnt(retire_cnt), .done(done),
`ifdef TRACE_CYCLE_STAMP_EN
        .rd_cycle(rd_cycle),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] wb_mask;
        logic [11:0] rd_mask;
        logic [15:0] exp_retire;
        logic [3:0]  exp_count;
        logic        exp_ovf;
    } vec_t;

    vec_t              vecs[6];
    logic              wb_v[LIMIT];
    logic [REG_AW-1:0] addr_v[LIMIT];
    logic [DATA_W-1:0] data_v[LIMIT];
    logic              rd_v[LIMIT];
    logic [EW-1:0]     exp_q[$];
    int                n_tests = 0;
    int                n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_head(input logic [EW-1:0] head);
        check("rd_valid_head", rd_valid, 1);
        check("rd_addr_head", rd_addr, head[EW-1 -: REG_AW]);
        check("rd_data_head", rd_data, head[DATA_W+15:16]);
`ifdef TRACE_CYCLE_STAMP_EN
        check("rd_cycle_head", rd_cycle, head[15:0]);
`endif
    endtask

    task automatic check_all_zero();
        check("rst_run_en", run_en, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_cycle_cnt", cycle_cnt, 0);
        check("rst_retire_cnt", retire_cnt, 0);
        check("rst_done", done, 0);
        check("rst_state", dbg_state, 0);
    endtask

    task automatic clear_pattern();
        for (int c = 0; c < LIMIT; c++) begin
            wb_v[c] = 1'b0; addr_v[c] = '0; data_v[c] = '0; rd_v[c] = 1'b0;
        end
    endtask

    task automatic run_window();
        int n_run;
        logic [EW-1:0] head;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_run = 0;
        for (int c = 0; c < 2 * LIMIT; c++) begin
            if (!run_en) break;
            check("cycle_cnt_run", cycle_cnt, c);
            if (c < LIMIT) begin
                wb_en = wb_v[c]; wb_addr = addr_v[c]; wb_data = data_v[c]; rd_en = rd_v[c];
            end else begin
                wb_en = 1'b0; rd_en = 1'b0;
            end
            if (rd_en && exp_q.size() > 0) begin
                head = exp_q.pop_front();
                check_head(head);
            end
            if (wb_en && exp_q.size() < DEPTH)
                exp_q.push_back({wb_addr, wb_data, 16'(c)});
            n_run++;
            tick();
        end
        wb_en = 1'b0;
        rd_en = 1'b0;
        check("run_len", n_run, LIMIT);
        check("cycle_cnt_end", cycle_cnt, LIMIT);
        check("drain_state", dbg_state, 2);
        check("done_in_drain", done, 0);
    endtask

    task automatic drain();
        logic [EW-1:0] head;
        for (int k = 0; k < 2 * DEPTH && rd_valid; k++) begin
            if (exp_q.size() == 0) begin
                check("unexpected_entry", 1, 0);
                break;
            end
            head = exp_q.pop_front();
            check_head(head);
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        check("drain_left", exp_q.size(), 0);
        check("count_empty", fifo_count, 0);
        check("rd_valid_empty", rd_valid, 0);
        check("rd_addr_empty", rd_addr, 0);
        check("rd_data_empty", rd_data, 0);
        check("done_before", done, 0);
        tick();
        check("done_after", done, 1);
        check("done_state", dbg_state, 3);
        check("run_en_done", run_en, 0);
    endtask

    initial begin
        vecs[0] = '{12'h000, 12'h000, 16'd0,  4'd0, 1'b0};
        vecs[1] = '{12'hFFF, 12'h000, 16'd12, 4'd8, 1'b1};
        vecs[2] = '{12'h1FF, 12'h100, 16'd9,  4'd8, 1'b0};
        vecs[3] = '{12'h0FF, 12'h000, 16'd8,  4'd8, 1'b0};
        vecs[4] = '{12'h1FF, 12'h000, 16'd9,  4'd8, 1'b1};
        vecs[5] = '{12'hAAA, 12'h445, 16'd6,  4'd3, 1'b0};

        #1 rst_n = 1'b0;
        #2 check_all_zero();
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_hold", dbg_state, 0);

        for (int v = 0; v < 6; v++) begin
            for (int c = 0; c < LIMIT; c++) begin
                wb_v[c]   = vecs[v].wb_mask[c];
                addr_v[c] = REG_AW'(c + 1);
                data_v[c] = 32'hC0DE_0000 + 32'(c);
                rd_v[c]   = vecs[v].rd_mask[c];
            end
            run_window();
            check("tbl_retire", retire_cnt, vecs[v].exp_retire);
            check("tbl_count", fifo_count, vecs[v].exp_count);
            check("tbl_overflow", overflow, vecs[v].exp_ovf);
            drain();
        end

        clear_pattern();
        wb_v[3] = 1'b1; addr_v[3] = 5'd1; data_v[3] = 32'd5;
        wb_v[4] = 1'b1; addr_v[4] = 5'd2; data_v[4] = 32'd7;
        wb_v[6] = 1'b1; addr_v[6] = 5'd3; data_v[6] = 32'd12;
        run_window();
        check("seq2_retire", retire_cnt, 3);
        check("seq2_overflow", overflow, 0);
        check("seq2_count", fifo_count, 3);
        check("seq2_first_addr", rd_addr, 1);
        check("seq2_first_data", rd_data, 5);
        drain();

        clear_pattern();
        wb_v[4] = 1'b1; addr_v[4] = 5'd9; data_v[4] = 32'hBEEF;
        run_window();
`ifdef TRACE_CYCLE_STAMP_EN
        check("stamp_cycle4", rd_cycle, 4);
`endif
        drain();

        // Reset asserted between edges at run cycle 5 must clear everything at once.
        start = 1'b1;
        tick();
        start = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h55;
        for (int c = 0; c < 5; c++) tick();
        wb_en = 1'b0;
        check("pre_rst_cycle", cycle_cnt, 5);
        check("pre_rst_count", fifo_count, 5);
        #2 rst_n = 1'b0;
        #1 check_all_zero();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        tick();
        check("post_rst_idle", dbg_state, 0);
        check("post_rst_run_en", run_en, 0);
        clear_pattern();
        run_window();
        check("post_rst_retire", retire_cnt, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
